card_pair_controller: RTL and testbench

//  Sequences one round of the memory game while the top-level FSM is in its draw-cards state.

---
 rtl/card_pair_controller_pkg.sv | 22 ++
 rtl/card_pair_controller_timer.sv | 23 ++
 rtl/card_pair_controller.sv | 136 +++++++++++++
 tb/tb_card_pair_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pair_controller_pkg.sv
// Shared state encoding and helpers for the memory-game card pair controller.
package card_pair_controller_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_FIRST,
    S_RD_FIRST,
    S_LAT_FIRST,
    S_WAIT_SECOND,
    S_RD_SECOND,
    S_LAT_SECOND,
    S_COMPARE,
    S_SHOW,
    S_DONE
  } state_t;

  // Only the click-waiting states (and IDLE) count as not busy.
  function automatic logic is_busy(state_t s);
    return !(s == S_IDLE || s == S_WAIT_FIRST || s == S_WAIT_SECOND);
  endfunction

endpackage

// File: rtl/card_pair_controller_timer.sv
// Loadable down-counter that holds the mismatched pair face-up.
module delay_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst)                      r_cnt <= '0;
    else if (load)                 r_cnt <= load_val;
    else if (tick && r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/card_pair_controller.sv
// Runs one round of the memory game: take two card picks, read colours, keep pairs or flip back.
module card_pair_controller
  import card_pair_controller_pkg::*;
#(
  parameter int NUM_CARDS   = 15,
  parameter int ADDR_W      = 4,
  parameter int COLOR_W     = 12,
  parameter int SHOW_CYCLES = 65_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 click_valid,
  input  logic [ADDR_W-1:0]    click_addr,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [COLOR_W-1:0]   rd_data,
  output logic [NUM_CARDS-1:0] face_up,
  output logic [NUM_CARDS-1:0] matched,
  output logic [ADDR_W-1:0]    pairs_found,
  output logic                 busy,
  output logic                 game_done
);

  localparam int TW = (SHOW_CYCLES > 2) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] HALF = ADDR_W'(NUM_CARDS / 2);
  localparam int MASK_W = 2 ** ADDR_W;

  state_t r_state, w_next;
  logic [ADDR_W-1:0]    r_idx1, r_idx2;
  logic [COLOR_W-1:0]   r_col1, r_col2;
  logic [NUM_CARDS-1:0] w_oh1, w_oh2, w_click_oh;
  logic [MASK_W-1:0]    w_taken;
  logic [ADDR_W-1:0]    w_pairs_inc;
  logic w_accept, w_abort, w_match, w_load, w_tick, w_zero;

  // Widen the taken mask so any click_addr can index it, even past NUM_CARDS.
  assign w_taken     = MASK_W'(face_up | matched);
  assign w_accept    = click_valid && enable &&
                       (r_state == S_WAIT_FIRST || r_state == S_WAIT_SECOND) &&
                       ({1'b0, click_addr} < (ADDR_W+1)'(NUM_CARDS)) && !w_taken[click_addr];
  assign w_abort     = (r_state != S_IDLE) && !enable;
  assign w_match     = (r_col1 == r_col2);
  assign w_oh1       = NUM_CARDS'(1) << r_idx1;
  assign w_oh2       = NUM_CARDS'(1) << r_idx2;
  assign w_click_oh  = NUM_CARDS'(1) << click_addr;
  assign w_pairs_inc = (pairs_found < HALF) ? pairs_found + 1'b1 : HALF;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_tick = 1'b0;
    case (r_state)
      S_IDLE:        if (enable) w_next = S_WAIT_FIRST;
      S_WAIT_FIRST:  if (w_accept) w_next = S_RD_FIRST;
      S_RD_FIRST:    w_next = S_LAT_FIRST;
      S_LAT_FIRST:   w_next = S_WAIT_SECOND;
      S_WAIT_SECOND: if (w_accept) w_next = S_RD_SECOND;
      S_RD_SECOND:   w_next = S_LAT_SECOND;
      S_LAT_SECOND:  w_next = S_COMPARE;
      S_COMPARE: begin
        if (w_match) w_next = (w_pairs_inc == HALF) ? S_DONE : S_WAIT_FIRST;
        else begin
          w_load = 1'b1;
          w_next = S_SHOW;
        end
      end
      S_SHOW: begin
        if (w_zero) w_next = S_WAIT_FIRST;
        else        w_tick = 1'b1;
      end
      S_DONE:        w_next = S_DONE;
      default:       w_next = S_IDLE;
    endcase
    if (w_abort) begin
      w_next = S_IDLE;
      w_load = 1'b0;
      w_tick = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_addr     <= '0;
      face_up     <= '0;
      matched     <= '0;
      pairs_found <= '0;
      r_idx1      <= '0;
      r_idx2      <= '0;
      r_col1      <= '0;
      r_col2      <= '0;
    end else if (w_abort) begin
      // Found pairs stay visible so draw_cards can keep showing them until re-entry.
      face_up <= face_up & matched;
    end else begin
      case (r_state)
        S_IDLE: if (enable) begin
          face_up     <= '0;
          matched     <= '0;
          pairs_found <= '0;
        end
        S_WAIT_FIRST, S_WAIT_SECOND: if (w_accept) begin
          rd_addr <= click_addr;
          face_up <= face_up | w_click_oh;
          if (r_state == S_WAIT_FIRST) r_idx1 <= click_addr;
          else                         r_idx2 <= click_addr;
        end
        S_LAT_FIRST:  r_col1 <= rd_data;
        S_LAT_SECOND: r_col2 <= rd_data;
        S_COMPARE: if (w_match) begin
          matched     <= matched | w_oh1 | w_oh2;
          pairs_found <= w_pairs_inc;
        end
        S_SHOW: if (w_zero) face_up <= face_up & ~(w_oh1 | w_oh2);
        default: ;
      endcase
    end
  end

  delay_timer #(.W(TW)) u_show_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (TW'(SHOW_CYCLES - 1)),
    .tick     (w_tick),
    .zero     (w_zero)
  );

  assign busy      = is_busy(r_state);
  assign game_done = (r_state == S_DONE);

endmodule

// File: tb/tb_card_pair_controller.sv
// Randomized bench for card_pair_controller against a transaction-level game model.
module tb_card_pair_controller;

  localparam int N = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        click_valid;
  logic [3:0]  click_addr;
  logic [3:0]  rd_addr;
  logic [11:0] rd_data;
  logic [14:0] face_up, matched;
  logic [3:0]  pairs_found;
  logic        busy, game_done;

  card_pair_controller #(.NUM_CARDS(15), .ADDR_W(4), .COLOR_W(12), .SHOW_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .click_valid(click_valid), .click_addr(click_addr),
    .rd_addr(rd_addr), .rd_data(rd_data), .face_up(face_up), .matched(matched),
    .pairs_found(pairs_found), .busy(busy), .game_done(game_done)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [16];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Game model: what the board should look like once the DUT has settled.
  logic [14:0] m_fu, m_m;
  int          m_pairs, m_first;
  logic [3:0]  m_rd;
  bit          m_idle, m_wait2, m_done, m_busy;
  int          partner [16];

  task automatic model_click(input int a);
    if (m_idle || m_busy || m_done || a >= N) return;
    if (m_fu[a] || m_m[a]) return;
    m_rd    = 4'(a);
    m_fu[a] = 1'b1;
    m_busy  = 1'b1;
    if (!m_wait2) begin
      m_first = a;
      m_wait2 = 1'b1;
    end else begin
      m_wait2 = 1'b0;
      if (mem[m_first] == mem[a]) begin
        m_m[a] = 1'b1;
        m_m[m_first] = 1'b1;
        m_pairs++;
        if (m_pairs == N / 2) m_done = 1'b1;
      end else begin
        m_fu[a] = 1'b0;
        m_fu[m_first] = 1'b0;
      end
    end
  endtask

  task automatic model_drop();
    if (m_idle) return;
    m_fu = m_fu & m_m;
    m_idle = 1'b1; m_wait2 = 1'b0; m_done = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_enable();
    m_fu = '0; m_m = '0; m_pairs = 0;
    m_idle = 1'b0; m_wait2 = 1'b0; m_done = 1'b0; m_busy = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int a);
    click_valid = 1'b1;
    click_addr  = 4'(a);
    model_click(a);
    step();
    click_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (16) step();
    m_busy = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".face_up"},  32'(face_up),     32'(m_fu));
    check({tag, ".matched"},  32'(matched),     32'(m_m));
    check({tag, ".pairs"},    32'(pairs_found), 32'(m_pairs));
    check({tag, ".done"},     32'(game_done),   32'(m_done));
    check({tag, ".busy"},     32'(busy),        32'(m_done));
    check({tag, ".rd_addr"},  32'(rd_addr),     32'(m_rd));
  endtask

  task automatic new_layout();
    int perm [15];
    int j, t;
    for (int i = 0; i < 15; i++) perm[i] = i;
    for (int i = 14; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int p = 0; p < 7; p++) begin
      mem[perm[2*p]]       = {4'(p), 8'($urandom)};
      mem[perm[2*p+1]]     = mem[perm[2*p]];
      partner[perm[2*p]]   = perm[2*p+1];
      partner[perm[2*p+1]] = perm[2*p];
    end
    mem[perm[14]] = {4'hF, 8'($urandom)};
    partner[perm[14]] = perm[14];
    mem[15] = '0;
    partner[15] = 15;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, a, s;
    // Fixed layout: pairs (0,5) (1,6) (2,7) (3,8) (4,9) (10,11) (12,13), card 14 odd.
    mem[0] = 12'h0AA; mem[5]  = 12'h0AA;
    mem[1] = 12'hF00; mem[6]  = 12'hF00;
    mem[2] = 12'h00F; mem[7]  = 12'h00F;
    mem[3] = 12'h123; mem[8]  = 12'h123;
    mem[4] = 12'h456; mem[9]  = 12'h456;
    mem[10] = 12'h789; mem[11] = 12'h789;
    mem[12] = 12'hABC; mem[13] = 12'hABC;
    mem[14] = 12'hFFF; mem[15] = 12'h000;
    m_fu = '0; m_m = '0; m_pairs = 0; m_first = 0; m_rd = '0;
    m_idle = 1'b1; m_wait2 = 1'b0; m_done = 1'b0; m_busy = 1'b0;

    // T1: reset with random inputs
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enable = 1'($urandom); click_valid = 1'($urandom); click_addr = 4'($urandom);
      step();
    end
    check_all("reset");
    enable = 1'b0; click_valid = 1'b0; click_addr = '0;
    rst = 1'b1;
    step();
    check("idle.busy", 32'(busy), 32'd0);
    enable = 1'b1;
    step();
    model_enable();

    // T2: matching pair 0/5
    pulse(0);
    check("t2.rd_addr_next", 32'(rd_addr), 32'd0);
    check("t2.busy_rd", 32'(busy), 32'd1);
    repeat (3) step();
    m_busy = 1'b0;
    pulse(5);
    settle();
    check("t2.matched", 32'(matched), 32'h0021);
    check_all("t2");

    // T3: mismatch 1/2, visible for exactly 8 cycles; clicks while busy dropped
    pulse(1);
    settle();
    pulse(2);
    check("t3.busy_rd", 32'(busy), 32'd1);
    click_valid = 1'b1; click_addr = 4'd3; model_click(3);
    step();
    click_valid = 1'b0;
    step();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ((face_up & 15'h0006) == 15'h0006) cnt++;
      if (i == 4) begin click_valid = 1'b1; click_addr = 4'd4; model_click(4); end
      else click_valid = 1'b0;
    end
    m_busy = 1'b0;
    check("t3.show_cycles", 32'(cnt), 32'd8);
    check_all("t3");

    // T4: illegal clicks leave everything unchanged
    pulse(3);  settle(); check_all("t4.first");
    pulse(3);  settle(); check_all("t4.repeat");
    pulse(15); settle(); check_all("t4.oob");
    pulse(0);  settle(); check_all("t4.matched_card");
    pulse(8);  settle(); check_all("t4.pair");

    // T5: finish the board
    pulse(1); settle(); pulse(6);  settle();
    pulse(2); settle(); pulse(7);  settle();
    pulse(4); settle(); pulse(9);  settle();
    pulse(10); settle(); pulse(11); settle();
    pulse(12); settle(); pulse(13); settle();
    check("t5.game_done", 32'(game_done), 32'd1);
    check("t5.pairs", 32'(pairs_found), 32'd7);
    check_all("t5");
    pulse(14); settle(); check_all("t5.after_done");

    // T6: drop and re-raise enable
    enable = 1'b0; step(); model_drop();
    check_all("t6.drop_done");
    enable = 1'b1; step(); model_enable();
    check_all("t6.reenter");

    // Randomized games
    for (int g = 0; g < 3; g++) begin
      enable = 1'b0; step(); model_drop();
      new_layout();
      enable = 1'b1; step(); model_enable();
      for (int k = 0; k < ((g == 2) ? 6 : 400) && !m_done; k++) begin
        if (m_wait2 && $urandom_range(0, 1) == 1) a = partner[m_first];
        else a = $urandom_range(0, 15);
        s = m_wait2 ? 1 : 0;
        pulse(a);
        if (s == 1 && $urandom_range(0, 1) == 1) begin
          a = $urandom_range(0, 15);
          click_valid = 1'b1; click_addr = 4'(a); model_click(a);
          step();
          click_valid = 1'b0;
        end
        settle();
        check_all($sformatf("rand.g%0d", g));
      end
    end

    // Enable falls while the second card is being read
    a = 0;
    while (a < N && (m_fu[a] || m_m[a])) a++;
    cnt = a + 1;
    while (cnt < N && (m_fu[cnt] || m_m[cnt])) cnt++;
    if (m_wait2 || m_done || cnt >= N) begin
      enable = 1'b0; step(); model_drop();
      enable = 1'b1; step(); model_enable();
      a = 0; cnt = 1;
    end
    pulse(a); settle();
    click_valid = 1'b1; click_addr = 4'(cnt);
    step();
    click_valid = 1'b0;
    m_rd = 4'(cnt);
    enable = 1'b0;
    step();
    model_drop();
    check_all("t6.rd_second_drop");
    check("t6.face_eq_matched", 32'(face_up), 32'(matched));

    // Simultaneous click and enable fall: click is lost
    enable = 1'b1; step(); model_enable();
    check_all("t6.reenable");
    enable = 1'b0; click_valid = 1'b1; click_addr = 4'd0;
    step();
    click_valid = 1'b0;
    model_drop();
    step();
    check_all("t6.click_on_fall");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
